// File: rtl/pipeline_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_if
//   Bundle between the stall/flush controller and the 6-stage pipeline.
//   master : the controller (takes stall/exception requests, drives
//            stall/flush/new_pc and the perf counters)
//   slave  : the pipeline side (drives requests, consumes the controls)
//
//   stallreq_if/id/ex/mem  per-stage stall requests
//   excp_req, excp_is_eret MEM-stage exception / ERET report
//   cp0_epc [31:0]         ERET target
//   stall [5:0]            bit k holds stage k (0 = PC ... 5 = WB)
//   flush                  clears all pipeline registers
//   new_pc [31:0]          redirect target, valid while flush = 1
//   stall_cnt, flush_cnt   perf counters (zero unless PIPELINE_PERF_CNT_EN)
// ---------------------------------------------------------------------------
interface pipeline_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             stallreq_if;
  logic             stallreq_id;
  logic             stallreq_ex;
  logic             stallreq_mem;
  logic             excp_req;
  logic             excp_is_eret;
  logic [31:0]      cp0_epc;
  logic [5:0]       stall;
  logic             flush;
  logic [31:0]      new_pc;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    input  excp_req, excp_is_eret, cp0_epc,
    output stall, flush, new_pc, stall_cnt, flush_cnt
  );

  modport slave (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    output excp_req, excp_is_eret, cp0_epc,
    input  stall, flush, new_pc, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//   Central stall/flush controller for the 6-stage pipeline
//   (PC, IF, ID, EX, MEM, WB).
//   - Merges per-stage stall requests into stall[5:0] (highest stage wins).
//   - Sequences exception/ERET recovery: FREEZE (1 cycle), FLUSH
//     (FLUSH_CYCLES cycles, new_pc valid), then back to RUN.
//   - Defers an exception reported during a MEM stall (WAIT) until the
//     MEM stall clears.
//
// Ports
//   clk    in  pipeline clock, rising edge
//   reset  in  asynchronous, active-high reset
//   bus    pipeline_ctrl_if.master (requests in, stall/flush/new_pc/counters out)
//
// Parameters
//   EXC_VECTOR    redirect target for a non-ERET exception
//   FLUSH_CYCLES  cycles flush is held high, 1..7
//   CNT_W         perf counter width
//
// Build option
//   PIPELINE_PERF_CNT_EN : when defined, builds saturating stall_cnt and
//   flush_cnt counters; otherwise both outputs are tied to zero.
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input logic             clk,
  input logic             reset,
  pipeline_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_WAIT   = 2'd1,
    S_FREEZE = 2'd2,
    S_FLUSH  = 2'd3
  } state_e;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [2:0]  fcnt_q, fcnt_d;
  logic [31:0] tgt_q, tgt_d;        // target captured at acceptance
  logic [31:0] new_pc_q, new_pc_d;  // published target, changes only on FLUSH entry
  logic        flush_q;
  logic [5:0]  stall_enc;
  logic [5:0]  stall_d;

  // Priority encode: a stalled stage must also hold every earlier stage.
  always_comb begin
    if (bus.stallreq_mem)     stall_enc = 6'b011111;
    else if (bus.stallreq_ex) stall_enc = 6'b001111;
    else if (bus.stallreq_id) stall_enc = 6'b000111;
    else if (bus.stallreq_if) stall_enc = 6'b000011;
    else                      stall_enc = 6'b000000;
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    tgt_d    = tgt_q;
    new_pc_d = new_pc_q;
    stall_d  = stall_enc;

    unique case (state_q)
      S_RUN: begin
        if (bus.excp_req) begin
          tgt_d   = bus.excp_is_eret ? bus.cp0_epc : EXC_VECTOR;
          // A pending dcache miss must finish before the pipe is torn down.
          state_d = bus.stallreq_mem ? S_WAIT : S_FREEZE;
        end
      end
      S_WAIT: begin
        if (!bus.stallreq_mem) state_d = S_FREEZE;
      end
      S_FREEZE: begin
        // Hold everything, including WB, so the excepting instruction never commits.
        stall_d  = 6'b111111;
        fcnt_d   = FLUSH_LOAD;
        new_pc_d = tgt_q;
        state_d  = S_FLUSH;
      end
      S_FLUSH: begin
        stall_d = 6'b000000;
        fcnt_d  = fcnt_q - 3'd1;
        if (fcnt_q <= 3'd1) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_RUN;
      fcnt_q   <= 3'd0;
      tgt_q    <= 32'd0;
      new_pc_q <= 32'd0;
      flush_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      tgt_q    <= tgt_d;
      new_pc_q <= new_pc_d;
      // Dedicated flop so flush is glitch-free and mirrors state == FLUSH.
      flush_q  <= (state_d == S_FLUSH);
    end
  end

  assign bus.stall  = stall_d;
  assign bus.flush  = flush_q;
  assign bus.new_pc = new_pc_q;

`ifdef PIPELINE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((stall_d != 6'b000000) && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      // FREEZE always exits to FLUSH, so this counts FLUSH entries.
      if ((state_q == S_FREEZE) && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
`endif

endmodule
